// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared opcodes, FSM states and helpers for alu_arbiter
package alu_arbiter_pkg;

  localparam logic [3:0] OP_SLL  = 4'h0;
  localparam logic [3:0] OP_SRL  = 4'h1;
  localparam logic [3:0] OP_SRA  = 4'h2;
  localparam logic [3:0] OP_ROL  = 4'h3;
  localparam logic [3:0] OP_MUL  = 4'h4;
  localparam logic [3:0] OP_IDLE = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Opcodes 0..4 are the only ones the shared ALU understands.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_MUL);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, ALU and response signals of alu_arbiter
interface alu_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*32-1:0] req_a;
  logic [N_REQ*32-1:0] req_b;
  logic [N_REQ*4-1:0]  req_op;

  logic [31:0]         alu_a;
  logic [31:0]         alu_b;
  logic [3:0]          alu_op;
  logic [63:0]         alu_result;
  logic                alu_valid;

  logic                rsp_valid;
  logic [ID_W-1:0]     rsp_id;
  logic [63:0]         rsp_result;
  logic                rsp_err;

  logic                halt_req;
  logic                halted;
  logic                busy;

  // The arbiter itself.
  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_result, alu_valid, halt_req,
    output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, rsp_err,
           halted, busy
  );

  // Requesters, ALU and response consumer seen as one environment.
  modport master (
    output req_valid, req_a, req_b, req_op, alu_result, alu_valid, halt_req,
    input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, rsp_err,
           halted, busy
  );

endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// rtl/alu_arbiter_rr_arbiter.sv - round-robin one-hot grant starting after last_grant
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_grant,
  output logic [N_REQ-1:0]         grant
);
  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0] pos;
  logic            found;

  // Walk last_grant+1, +2, ... wrapping, and grant the first active request.
  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = ID_W'((int'(last_grant) + k) % N_REQ);
      if (!found && req[pos]) begin
        grant[pos] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one pipelined ALU between requesters
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int         N_REQ   = 4,
  parameter logic [3:0] IDLE_OP = OP_IDLE
) (
  input logic       clk,
  input logic       rst,
  alu_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);

  state_t          state, state_nxt;
  logic [ID_W-1:0] last_grant;
  logic [N_REQ-1:0] run_req;
  logic [N_REQ-1:0] grant;
  logic            run_ok;
  logic            xfer;
  logic [ID_W-1:0] grant_id;
  logic [31:0]     sel_a, sel_b;
  logic [3:0]      sel_op;
  logic            sel_legal;

  logic            t1_valid, t2_valid;
  logic [ID_W-1:0] t1_id, t2_id;
  logic            t1_ill, t2_ill;
  logic            busy_w;

  // Requests are only eligible while running and out of reset.
  assign run_ok  = (state == ST_RUN) && !rst;
  assign run_req = bus.req_valid & {N_REQ{run_ok}};

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req        (run_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign bus.req_ready = grant;
  assign xfer          = |grant;
  assign sel_legal     = op_is_legal(sel_op);
  assign busy_w        = t1_valid | t2_valid;
  assign bus.busy      = busy_w;
  assign bus.halted    = (state == ST_HALTED);

  // Encode the one-hot grant and pick the granted payload.
  always_comb begin
    grant_id = '0;
    sel_a    = '0;
    sel_b    = '0;
    sel_op   = IDLE_OP;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        grant_id = ID_W'(i);
        sel_a    = bus.req_a[i*32 +: 32];
        sel_b    = bus.req_b[i*32 +: 32];
        sel_op   = bus.req_op[i*4 +: 4];
      end
    end
  end

  // Run/drain/halt sequencing driven by the halt_req level.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (bus.halt_req) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!bus.halt_req)  state_nxt = ST_RUN;
        else if (!busy_w)   state_nxt = ST_HALTED;
      end
      ST_HALTED: if (!bus.halt_req) state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // State register and round-robin pointer; pointer moves only on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      last_grant <= ID_W'(N_REQ - 1);
    end else begin
      state <= state_nxt;
      if (xfer) last_grant <= grant_id;
    end
  end

  // ALU operand/opcode registers; idle cycles present IDLE_OP with operands held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.alu_a  <= '0;
      bus.alu_b  <= '0;
      bus.alu_op <= IDLE_OP;
    end else if (xfer) begin
      bus.alu_a  <= sel_a;
      bus.alu_b  <= sel_b;
      bus.alu_op <= sel_legal ? sel_op : IDLE_OP;
    end else begin
      bus.alu_op <= IDLE_OP;
    end
  end

  // Two-stage tag pipeline matching the operand register plus ALU latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t1_valid <= 1'b0;
      t1_id    <= '0;
      t1_ill   <= 1'b0;
      t2_valid <= 1'b0;
      t2_id    <= '0;
      t2_ill   <= 1'b0;
    end else begin
      t1_valid <= xfer;
      t1_id    <= grant_id;
      t1_ill   <= xfer && !sel_legal;
      t2_valid <= t1_valid;
      t2_id    <= t1_id;
      t2_ill   <= t1_ill;
    end
  end

  // Response register: pairs the oldest tag with the ALU result, zeroing errored data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= '0;
      bus.rsp_result <= '0;
      bus.rsp_err    <= 1'b0;
    end else begin
      bus.rsp_valid  <= t2_valid;
      if (t2_valid) bus.rsp_id <= t2_id;
      bus.rsp_err    <= t2_valid && (t2_ill || !bus.alu_valid);
      bus.rsp_result <= (t2_valid && !t2_ill && bus.alu_valid) ? bus.alu_result : 64'd0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter
module tb_alu_arbiter;
  localparam int N = 4;
  localparam int W = 2;
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2;

  logic clk = 1'b0;
  logic rst;
  logic alu_rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if #(.N_REQ(N)) bus ();
  alu_arbiter #(.N_REQ(N), .IDLE_OP(4'hF)) dut (.clk(clk), .rst(rst), .bus(bus));

  assign alu_rst_n = ~rst;

  // Behaviour of the shared ALU for one operation.
  function automatic logic [63:0] alu_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned s;
    logic [31:0] r;
    s = b % 32;
    case (op)
      4'h0: return {32'd0, a << s};
      4'h1: return {32'd0, a >> s};
      4'h2: begin r = 32'($signed(a) >>> s); return {32'd0, r}; end
      4'h3: begin r = a; for (int unsigned k = 0; k < s; k++) r = {r[30:0], r[31]}; return {32'd0, r}; end
      4'h4: return 64'(a) * 64'(b);
      default: return 64'hBAD0_BAD0_BAD0_BAD0;
    endcase
  endfunction

  // One-cycle registered ALU; valid only for opcodes it implements.
  always @(posedge clk or negedge alu_rst_n) begin
    if (!alu_rst_n) begin
      bus.alu_result <= '0;
      bus.alu_valid  <= 1'b0;
    end else begin
      bus.alu_result <= alu_calc(bus.alu_op, bus.alu_a, bus.alu_b);
      bus.alu_valid  <= (bus.alu_op <= 4'h4);
    end
  end

  typedef struct {
    int          due;
    logic [W-1:0] id;
    logic [63:0] res;
    logic        err;
  } rsp_t;

  rsp_t        q[$];
  int          m_last, m_state, edge_n, gnt_idx;
  int          n_checks, n_fail;
  logic [31:0] pa[N], pb[N];
  logic [3:0]  po[N];
  logic [N-1:0] obs_ready, exp_ready;
  logic        obs_rv, exp_rv, obs_err, exp_err;
  logic [W-1:0] obs_id, exp_id;
  logic [63:0] obs_res, exp_res;
  logic [3:0]  obs_op, exp_op;
  logic [31:0] obs_a, exp_a;
  logic        obs_halted, exp_halted, obs_busy, exp_busy;

  task automatic model_reset();
    q.delete();
    m_last  = N - 1;
    m_state = M_RUN;
    exp_a   = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    bus.halt_req  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Drive one cycle of stimulus, advance the reference model, capture observations.
  task automatic run_cycle(input logic [N-1:0] v, input logic h);
    bit busy_before;
    bit legal;
    @(negedge clk);
    bus.req_valid = v;
    bus.halt_req  = h;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*32 +: 32] = pa[i];
      bus.req_b[i*32 +: 32] = pb[i];
      bus.req_op[i*4 +: 4]  = po[i];
    end
    #1;
    gnt_idx = -1;
    if (m_state == M_RUN)
      for (int k = 1; k <= N; k++)
        if (gnt_idx < 0 && v[(m_last + k) % N]) gnt_idx = (m_last + k) % N;
    exp_ready = '0;
    if (gnt_idx >= 0) exp_ready[gnt_idx] = 1'b1;
    obs_ready   = bus.req_ready;
    busy_before = (q.size() > 0);
    @(posedge clk);
    edge_n++;
    exp_op = 4'hF;
    if (gnt_idx >= 0) begin
      legal = (po[gnt_idx] <= 4'h4);
      q.push_back('{due: edge_n + 2, id: W'(gnt_idx),
                    res: legal ? alu_calc(po[gnt_idx], pa[gnt_idx], pb[gnt_idx]) : 64'd0,
                    err: !legal});
      m_last = gnt_idx;
      exp_a  = pa[gnt_idx];
      if (legal) exp_op = po[gnt_idx];
    end
    case (m_state)
      M_RUN:    if (h) m_state = M_DRAIN;
      M_DRAIN:  if (!h) m_state = M_RUN; else if (!busy_before) m_state = M_HALTED;
      default:  if (!h) m_state = M_RUN;
    endcase
    #1;
    exp_rv = 1'b0; exp_id = '0; exp_res = '0; exp_err = 1'b0;
    if (q.size() > 0 && q[0].due == edge_n) begin
      exp_rv  = 1'b1;
      exp_id  = q[0].id;
      exp_res = q[0].res;
      exp_err = q[0].err;
      void'(q.pop_front());
    end
    exp_busy   = (q.size() > 0);
    exp_halted = (m_state == M_HALTED);
    obs_rv = bus.rsp_valid; obs_id = bus.rsp_id; obs_res = bus.rsp_result; obs_err = bus.rsp_err;
    obs_op = bus.alu_op; obs_a = bus.alu_a; obs_halted = bus.halted; obs_busy = bus.busy;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '1;
    for (int pass = 0; pass < 2; pass++) begin
      #1;
      n_checks++;
      if (bus.req_ready !== '0) begin
        n_fail++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready);
      end
      n_checks++;
      if ({bus.alu_a, bus.alu_b, bus.alu_op} !== {32'd0, 32'd0, 4'hF}) begin
        n_fail++; $display("FAIL reset_alu: got a=%h b=%h op=%h want 0 0 f", bus.alu_a, bus.alu_b, bus.alu_op);
      end
      n_checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_err, bus.halted, bus.busy} !== '0) begin
        n_fail++; $display("FAIL reset_rsp: got v=%b id=%0d res=%h err=%b halted=%b busy=%b want all 0",
                           bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_err, bus.halted, bus.busy);
      end
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = '0;
    model_reset();
  endtask

  task automatic test_mul();
    pa[0] = 32'd3; pb[0] = 32'd5; po[0] = 4'h4;
    run_cycle(4'b0001, 1'b0);
    n_checks++;
    if (obs_ready !== exp_ready) begin
      n_fail++; $display("FAIL mul_ready: got %b want %b", obs_ready, exp_ready);
    end
    for (int i = 0; i < 3; i++) begin
      run_cycle(4'b0000, 1'b0);
      n_checks++;
      if (obs_rv !== exp_rv || (exp_rv && {obs_id, obs_err, obs_res} !== {exp_id, exp_err, exp_res})) begin
        n_fail++; $display("FAIL mul_rsp: got v=%b id=%0d err=%b res=%h want v=%b id=%0d err=%b res=%h",
                           obs_rv, obs_id, obs_err, obs_res, exp_rv, exp_id, exp_err, exp_res);
      end
      if (i == 1) begin
        n_checks++;
        if ({obs_rv, obs_id, obs_err, obs_res} !== {1'b1, 2'd0, 1'b0, 64'd15}) begin
          n_fail++; $display("FAIL mul_value: got v=%b id=%0d err=%b res=%h want v=1 id=0 err=0 res=15",
                             obs_rv, obs_id, obs_err, obs_res);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] want;
    apply_reset();
    for (int i = 0; i < N; i++) begin
      pa[i] = $urandom; pb[i] = $urandom; po[i] = 4'($urandom_range(0, 4));
    end
    for (int k = 0; k < 10; k++) begin
      run_cycle(k < 8 ? 4'b1111 : 4'b0000, 1'b0);
      want = (k < 8) ? 4'(1 << (k % 4)) : 4'b0000;
      n_checks++;
      if (obs_ready !== exp_ready || obs_ready !== want) begin
        n_fail++; $display("FAIL rr_ready cycle %0d: got %b want %b", k, obs_ready, want);
      end
      n_checks++;
      if (obs_rv !== exp_rv || (exp_rv && {obs_id, obs_err, obs_res} !== {exp_id, exp_err, exp_res})
          || (k >= 2 && (obs_rv !== 1'b1 || obs_id !== W'((k - 2) % 4)))) begin
        n_fail++; $display("FAIL rr_rsp cycle %0d: got v=%b id=%0d res=%h want v=%b id=%0d res=%h",
                           k, obs_rv, obs_id, obs_res, exp_rv, exp_id, exp_res);
      end
      if (gnt_idx >= 0) begin
        pa[gnt_idx] = $urandom; pb[gnt_idx] = $urandom; po[gnt_idx] = 4'($urandom_range(0, 4));
      end
    end
  endtask

  task automatic test_illegal();
    pa[2] = $urandom; pb[2] = $urandom; po[2] = 4'h7;
    run_cycle(4'b0100, 1'b0);
    n_checks++;
    if (obs_op !== 4'hF || obs_op !== exp_op) begin
      n_fail++; $display("FAIL illegal_op: got %h want f", obs_op);
    end
    for (int i = 0; i < 2; i++) run_cycle(4'b0000, 1'b0);
    n_checks++;
    if ({obs_rv, obs_id, obs_err, obs_res} !== {1'b1, 2'd2, 1'b1, 64'd0} ||
        {obs_rv, obs_id, obs_err, obs_res} !== {exp_rv, exp_id, exp_err, exp_res}) begin
      n_fail++; $display("FAIL illegal_rsp: got v=%b id=%0d err=%b res=%h want v=1 id=2 err=1 res=0",
                         obs_rv, obs_id, obs_err, obs_res);
    end
  endtask

  task automatic test_rotate();
    pa[1] = 32'h8000_0001; pb[1] = 32'd1; po[1] = 4'h3;
    run_cycle(4'b0010, 1'b0);
    for (int i = 0; i < 2; i++) run_cycle(4'b0000, 1'b0);
    n_checks++;
    if ({obs_rv, obs_id, obs_err, obs_res} !== {1'b1, 2'd1, 1'b0, 64'h0000_0000_0000_0003}) begin
      n_fail++; $display("FAIL rotate_rsp: got v=%b id=%0d err=%b res=%h want v=1 id=1 err=0 res=3",
                         obs_rv, obs_id, obs_err, obs_res);
    end
  endtask

  task automatic test_halt();
    int seen;
    for (int i = 0; i < N; i++) begin
      pa[i] = $urandom; pb[i] = $urandom_range(1, 9); po[i] = 4'h4;
    end
    seen = 0;
    run_cycle(4'b0001, 1'b0);
    run_cycle(4'b0010, 1'b1);
    n_checks++;
    if (obs_ready !== exp_ready || obs_ready === 4'b0000) begin
      n_fail++; $display("FAIL halt_edge_xfer: got %b want %b", obs_ready, exp_ready);
    end
    for (int k = 0; k < 8; k++) begin
      run_cycle(4'b1111, 1'b1);
      if (obs_rv === 1'b1) seen++;
      n_checks++;
      if (obs_ready !== exp_ready || obs_halted !== exp_halted || obs_busy !== exp_busy) begin
        n_fail++; $display("FAIL halt_state cycle %0d: got ready=%b halted=%b busy=%b want ready=%b halted=%b busy=%b",
                           k, obs_ready, obs_halted, obs_busy, exp_ready, exp_halted, exp_busy);
      end
      n_checks++;
      if (obs_rv !== exp_rv || (exp_rv && {obs_id, obs_err, obs_res} !== {exp_id, exp_err, exp_res})) begin
        n_fail++; $display("FAIL halt_rsp cycle %0d: got v=%b id=%0d res=%h want v=%b id=%0d res=%h",
                           k, obs_rv, obs_id, obs_res, exp_rv, exp_id, exp_res);
      end
    end
    n_checks++;
    if (seen !== 2 || obs_halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_drained: got responses=%0d halted=%b want responses=2 halted=1", seen, obs_halted);
    end
    for (int k = 0; k < 5; k++) begin
      run_cycle(k < 2 ? 4'b1111 : 4'b0000, 1'b0);
      n_checks++;
      if (obs_ready !== exp_ready || obs_halted !== exp_halted || (k == 1 && obs_ready === 4'b0000)) begin
        n_fail++; $display("FAIL halt_resume cycle %0d: got ready=%b halted=%b want ready=%b halted=%b",
                           k, obs_ready, obs_halted, exp_ready, exp_halted);
      end
      n_checks++;
      if (obs_rv !== exp_rv || (exp_rv && {obs_id, obs_err, obs_res} !== {exp_id, exp_err, exp_res})) begin
        n_fail++; $display("FAIL resume_rsp cycle %0d: got v=%b id=%0d res=%h want v=%b id=%0d res=%h",
                           k, obs_rv, obs_id, obs_res, exp_rv, exp_id, exp_res);
      end
    end
  endtask

  task automatic test_reset_mid();
    pa[0] = 32'd7; pb[0] = 32'd6; po[0] = 4'h4;
    run_cycle(4'b0001, 1'b0);
    apply_reset();
    n_checks++;
    if ({bus.rsp_valid, bus.busy, bus.halted, bus.alu_a, bus.alu_op} !== {1'b0, 1'b0, 1'b0, 32'd0, 4'hF}) begin
      n_fail++; $display("FAIL midreset_state: got v=%b busy=%b halted=%b a=%h op=%h want 0 0 0 0 f",
                         bus.rsp_valid, bus.busy, bus.halted, bus.alu_a, bus.alu_op);
    end
    for (int k = 0; k < 4; k++) begin
      run_cycle(4'b0000, 1'b0);
      n_checks++;
      if (obs_rv !== 1'b0 || obs_rv !== exp_rv || obs_busy !== exp_busy) begin
        n_fail++; $display("FAIL midreset_rsp cycle %0d: got v=%b busy=%b want v=0 busy=%b", k, obs_rv, obs_busy, exp_busy);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    logic         h;
    apply_reset();
    pend = '0;
    h    = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 60) begin
          pend[i] = 1'b1;
          pa[i] = $urandom; pb[i] = $urandom; po[i] = 4'($urandom_range(0, 6));
        end
      end
      if (c >= 390) h = 1'b0;
      else if ($urandom_range(0, 99) < 6) h = ~h;
      run_cycle(pend, h);
      if (gnt_idx >= 0) pend[gnt_idx] = 1'b0;
      n_checks++;
      if (obs_ready !== exp_ready) begin
        n_fail++; $display("FAIL rand_ready cycle %0d: got %b want %b", c, obs_ready, exp_ready);
      end
      n_checks++;
      if (obs_rv !== exp_rv || (exp_rv && {obs_id, obs_err, obs_res} !== {exp_id, exp_err, exp_res})) begin
        n_fail++; $display("FAIL rand_rsp cycle %0d: got v=%b id=%0d err=%b res=%h want v=%b id=%0d err=%b res=%h",
                           c, obs_rv, obs_id, obs_err, obs_res, exp_rv, exp_id, exp_err, exp_res);
      end
      n_checks++;
      if ({obs_op, obs_a, obs_halted, obs_busy} !== {exp_op, exp_a, exp_halted, exp_busy}) begin
        n_fail++; $display("FAIL rand_status cycle %0d: got op=%h a=%h halted=%b busy=%b want op=%h a=%h halted=%b busy=%b",
                           c, obs_op, obs_a, obs_halted, obs_busy, exp_op, exp_a, exp_halted, exp_busy);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.halt_req  = 1'b0;
    bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
    n_checks = 0; n_fail = 0; edge_n = 0; gnt_idx = -1;
    for (int i = 0; i < N; i++) begin pa[i] = '0; pb[i] = '0; po[i] = '0; end
    model_reset();
    test_reset();
    test_mul();
    test_round_robin();
    test_illegal();
    test_rotate();
    test_halt();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
